// File: rtl/decoder_pkg.sv
// Shared decoder definitions: opcode constants, FSM states and decode helpers.
package decoder_pkg;

  localparam int unsigned FW = 32;

  localparam logic [4:0] OP_NOP    = 5'b00000;
  localparam logic [4:0] OP_LI     = 5'b00001;
  localparam logic [4:0] OP_LD     = 5'b00010;
  localparam logic [4:0] OP_ST     = 5'b00011;
  localparam logic [4:0] OP_SETACC = 5'b01010;
  localparam logic [4:0] OP_INC    = 5'b10001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    MEM    = 2'd2
  } state_t;

  // Opcodes arrive zero-extended to FW; opc_w selects the class MSB.
  function automatic logic is_legal(input logic [FW-1:0] op, input int unsigned opc_w);
    logic msb;
    msb = op[5'(opc_w - 1)];
    return msb || (op == FW'(OP_NOP)) || (op == FW'(OP_LI)) || (op == FW'(OP_LD)) ||
           (op == FW'(OP_ST)) || (op == FW'(OP_SETACC));
  endfunction

  function automatic logic is_mem(input logic [FW-1:0] op);
    return (op == FW'(OP_LD)) || (op == FW'(OP_ST));
  endfunction

  function automatic logic has_imm(input logic [FW-1:0] op);
    return (op == FW'(OP_LI)) || (op == FW'(OP_INC));
  endfunction

  // Zero- or sign-extend the low reg_w bits of field to FW bits.
  function automatic logic [FW-1:0] extend(input logic [FW-1:0] field, input int unsigned reg_w,
                                           input logic sgn);
    logic [FW-1:0] hi;
    logic [FW-1:0] res;
    hi  = {FW{1'b1}} << reg_w;
    res = field & ~hi;
    if (sgn && field[5'(reg_w - 1)]) res = res | hi;
    return res;
  endfunction

endpackage

// File: rtl/decoder_seq.sv
// Sequential instruction decoder: valid/ready accept, registered decode,
// LD/ST memory handshake with timeout, and PC-advance generation.
module decoder_seq
  import decoder_pkg::*;
#(
  parameter  int unsigned OPC_W       = 5,
  parameter  int unsigned REG_W       = 3,
  parameter  int unsigned DATA_W      = 8,
  parameter  int unsigned IMM_SIGNED  = 0,
  parameter  int unsigned MEM_TIMEOUT = 15,
  localparam int unsigned INSTR_W     = OPC_W + REG_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [OPC_W-1:0]   opcode,
  output logic [REG_W-1:0]   register,
  output logic [DATA_W-1:0]  imm,
  output logic               is_alu_op,
  output logic               is_mem_op,
  output logic               mem_rw,
  output logic               dec_valid,
  output logic               illegal,
  output logic               mem_req,
  input  logic               mem_ack,
  output logic               increment_pc,
  output logic               timeout_err,
  output logic               busy
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t             state, state_nxt;
  logic [INSTR_W-1:0] ir, ir_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [OPC_W-1:0]   op_in, op_nxt;
  logic               dec_valid_nxt, illegal_nxt, pc_nxt, timeout_nxt;
  logic               pc_q, ack_pc_c;

  assign op_in  = instr[INSTR_W-1:REG_W];
  assign op_nxt = ir_nxt[INSTR_W-1:REG_W];

  // Next-state and next-pulse logic.
  always_comb begin
    state_nxt     = state;
    ir_nxt        = ir;
    cnt_nxt       = '0;
    dec_valid_nxt = 1'b0;
    illegal_nxt   = 1'b0;
    pc_nxt        = 1'b0;
    timeout_nxt   = 1'b0;
    ack_pc_c      = 1'b0;
    unique case (state)
      IDLE: begin
        if (instr_valid && instr_ready) begin
          ir_nxt        = instr;
          state_nxt     = DECODE;
          dec_valid_nxt = 1'b1;
          illegal_nxt   = !is_legal(FW'(op_in), OPC_W);
          pc_nxt        = !is_mem(FW'(op_in));
        end
      end
      DECODE: state_nxt = is_mem_op ? MEM : IDLE;
      MEM: begin
        if (mem_ack) begin
          ack_pc_c  = reset;
          state_nxt = IDLE;
        end else if (cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The ack-cycle PC advance must land in the same cycle as mem_ack.
  assign increment_pc = pc_q | ack_pc_c;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      ir          <= '0;
      cnt         <= '0;
      instr_ready <= 1'b0;
      busy        <= 1'b0;
      mem_req     <= 1'b0;
      dec_valid   <= 1'b0;
      illegal     <= 1'b0;
      pc_q        <= 1'b0;
      timeout_err <= 1'b0;
      opcode      <= '0;
      register    <= '0;
      imm         <= '0;
      is_alu_op   <= 1'b0;
      is_mem_op   <= 1'b0;
      mem_rw      <= 1'b0;
    end else begin
      state       <= state_nxt;
      ir          <= ir_nxt;
      cnt         <= cnt_nxt;
      instr_ready <= (state_nxt == IDLE);
      busy        <= (state_nxt != IDLE);
      mem_req     <= (state_nxt == MEM);
      dec_valid   <= dec_valid_nxt;
      illegal     <= illegal_nxt;
      pc_q        <= pc_nxt;
      timeout_err <= timeout_nxt;
      opcode      <= op_nxt;
      register    <= ir_nxt[REG_W-1:0];
      imm         <= has_imm(FW'(op_nxt))
                     ? DATA_W'(extend(FW'(ir_nxt[REG_W-1:0]), REG_W, IMM_SIGNED != 0))
                     : '0;
      is_alu_op   <= op_nxt[OPC_W-1];
      is_mem_op   <= is_mem(FW'(op_nxt));
      mem_rw      <= op_nxt[0];
    end
  end

endmodule

// File: tb/tb_decoder_seq.sv
// Scoreboard bench for decoder_seq: directed instructions, decode and memory
// outcomes checked by a negedge monitor against hand-computed expectations.
module tb_decoder_seq;

  typedef struct {
    logic [4:0] op;
    logic [2:0] rg;
    logic [7:0] imm;
    logic [7:0] imm_s;
    logic       alu;
    logic       mem;
    logic       rw;
    logic       ill;
    logic       pc;
  } dec_exp_t;

  typedef struct {
    int kind;  // 0 = ack, 1 = timeout, 2 = reset abort
    int len;
  } mem_exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       instr_valid = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       mem_ack = 1'b0;

  logic       instr_ready, is_alu_op, is_mem_op, mem_rw, dec_valid, illegal;
  logic       mem_req, increment_pc, timeout_err, busy;
  logic [4:0] opcode;
  logic [2:0] register;
  logic [7:0] imm;

  logic       s_instr_ready, s_is_alu_op, s_is_mem_op, s_mem_rw, s_dec_valid, s_illegal;
  logic       s_mem_req, s_increment_pc, s_timeout_err, s_busy;
  logic [4:0] s_opcode;
  logic [2:0] s_register;
  logic [7:0] s_imm;

  int total = 0;
  int bad = 0;
  int run = 0;
  dec_exp_t dq[$];
  mem_exp_t mq[$];

  always #5 clk = ~clk;

  decoder_seq #(.OPC_W(5), .REG_W(3), .DATA_W(8), .IMM_SIGNED(0), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .opcode(opcode), .register(register), .imm(imm),
    .is_alu_op(is_alu_op), .is_mem_op(is_mem_op), .mem_rw(mem_rw),
    .dec_valid(dec_valid), .illegal(illegal), .mem_req(mem_req), .mem_ack(mem_ack),
    .increment_pc(increment_pc), .timeout_err(timeout_err), .busy(busy)
  );

  decoder_seq #(.OPC_W(5), .REG_W(3), .DATA_W(8), .IMM_SIGNED(1), .MEM_TIMEOUT(4)) dut_s (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(s_instr_ready),
    .instr(instr), .opcode(s_opcode), .register(s_register), .imm(s_imm),
    .is_alu_op(s_is_alu_op), .is_mem_op(s_is_mem_op), .mem_rw(s_mem_rw),
    .dec_valid(s_dec_valid), .illegal(s_illegal), .mem_req(s_mem_req), .mem_ack(mem_ack),
    .increment_pc(s_increment_pc), .timeout_err(s_timeout_err), .busy(s_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_dec(input logic [4:0] op, input logic [2:0] rg, input logic [7:0] im,
                         input logic [7:0] im_s, input logic alu, input logic mem,
                         input logic rw, input logic ill, input logic pc);
    dec_exp_t e;
    e = '{op, rg, im, im_s, alu, mem, rw, ill, pc};
    dq.push_back(e);
  endtask

  task automatic exp_mem(input int kind, input int len);
    mem_exp_t m;
    m = '{kind, len};
    mq.push_back(m);
  endtask

  // Called at a negedge; returns at the negedge of the DECODE cycle.
  task automatic send(input logic [7:0] w);
    int n;
    n = 0;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) chk("ready_wait", 32'(instr_ready), 32'(1));
    instr = w;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic mem_outcome(input int kind);
    mem_exp_t m;
    if (mq.size() == 0) begin
      chk("mem_unexpected", 32'(kind), 32'hFFFF_FFFF);
    end else begin
      m = mq.pop_front();
      chk("mem_kind", 32'(kind), 32'(m.kind));
      chk("mem_req_len", 32'(run), 32'(m.len));
    end
    run = 0;
  endtask

  // Monitor: decode scoreboard and memory-request outcome tracking.
  always @(negedge clk) begin
    dec_exp_t e;
    if (dec_valid) begin
      if (dq.size() == 0) begin
        chk("dec_unexpected", 32'(dec_valid), 32'(0));
      end else begin
        e = dq.pop_front();
        chk("opcode", 32'(opcode), 32'(e.op));
        chk("register", 32'(register), 32'(e.rg));
        chk("imm", 32'(imm), 32'(e.imm));
        chk("imm_signed", 32'(s_imm), 32'(e.imm_s));
        chk("s_dec_valid", 32'(s_dec_valid), 32'(1));
        chk("is_alu_op", 32'(is_alu_op), 32'(e.alu));
        chk("is_mem_op", 32'(is_mem_op), 32'(e.mem));
        chk("mem_rw", 32'(mem_rw), 32'(e.rw));
        chk("illegal", 32'(illegal), 32'(e.ill));
        chk("dec_increment_pc", 32'(increment_pc), 32'(e.pc));
        chk("dec_busy", 32'(busy), 32'(1));
        chk("dec_instr_ready", 32'(instr_ready), 32'(0));
      end
    end
    if (mem_req) begin
      run++;
      if (increment_pc) mem_outcome(0);
    end else if (run > 0) begin
      mem_outcome(timeout_err ? 1 : 2);
    end
  end

  initial begin
    int n;
    // Reset held with a valid instruction presented.
    instr = 8'h0D;
    instr_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_instr_ready", 32'(instr_ready), 32'(0));
    chk("rst_outputs", 32'({dec_valid, illegal, mem_req, increment_pc, timeout_err, busy,
                            is_alu_op, is_mem_op, mem_rw}), 32'(0));
    chk("rst_fields", 32'({opcode, register, imm}), 32'(0));
    reset = 1'b1;
    @(negedge clk);
    chk("rel_instr_ready", 32'(instr_ready), 32'(1));
    chk("rel_no_accept", 32'({dec_valid, busy}), 32'(0));
    instr_valid = 1'b0;

    // Non-memory instructions back to back.
    exp_dec(5'h01, 3'd5, 8'h05, 8'hFD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); send(8'h0D);
    exp_dec(5'h05, 3'd3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1); send(8'h2B);
    exp_dec(5'h0A, 3'd7, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); send(8'h57);
    exp_dec(5'h11, 3'd6, 8'h06, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1); send(8'h8E);
    exp_dec(5'h1F, 3'd1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1); send(8'hF9);
    exp_dec(5'h0F, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1); send(8'h78);
    exp_dec(5'h01, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); send(8'h08);
    exp_dec(5'h01, 3'd3, 8'h03, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); send(8'h0B);
    mem_ack = 1'b1;  // stray ack outside MEM
    exp_dec(5'h00, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); send(8'h00);
    mem_ack = 1'b0;

    // ST acknowledged in the third mem_req cycle.
    exp_dec(5'h03, 3'd2, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_mem(0, 3);
    send(8'h1A);
    repeat (3) @(posedge clk);
    #1 mem_ack = 1'b1;
    @(negedge clk);
    chk("st_ack_busy", 32'(busy), 32'(1));
    chk("st_ack_pc", 32'(increment_pc), 32'(1));
    @(posedge clk);
    #1 mem_ack = 1'b0;
    @(negedge clk);
    chk("st_after", 32'({busy, mem_req, increment_pc, instr_ready}), 32'(4'b0001));

    // LD never acknowledged: timeout after four request cycles.
    exp_dec(5'h02, 3'd4, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_mem(1, 4);
    send(8'h14);
    n = 0;
    while (!timeout_err && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("ld_timeout_seen", 32'(timeout_err), 32'(1));
    chk("ld_timeout_state", 32'({mem_req, increment_pc, instr_ready, busy}), 32'(4'b0010));
    @(negedge clk);
    chk("ld_timeout_pulse", 32'(timeout_err), 32'(0));

    // Reset during the second MEM cycle.
    exp_dec(5'h02, 3'd1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_mem(2, 2);
    send(8'h11);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_outputs", 32'({mem_req, increment_pc, busy, instr_ready}), 32'(0));
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(instr_ready), 32'(1));

    repeat (3) @(negedge clk);
    chk("dec_queue_empty", 32'(dq.size()), 32'(0));
    chk("mem_queue_empty", 32'(mq.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_seq.md
Name: decoder_seq

Overview:
- Parametrised, sequential successor to the single-cycle instruction decoder.
- Accepts instructions over a valid/ready handshake and latches them into an instruction register.
- Decodes the latched instruction into opcode, register, immediate and class flags, and drives a memory request/acknowledge handshake for LD/ST.
- Generates the PC-advance pulse for the fetch unit; sits between fetch and the ALU/memory datapath.

Parameters:
- OPC_W, 5, opcode field width (instr[INSTR_W-1:REG_W]).
- REG_W, 3, register/immediate field width (instr[REG_W-1:0]).
- DATA_W, 8, width of the extended immediate output; must be >= REG_W.
- IMM_SIGNED, 0, 1 = sign-extend immediate to DATA_W; 0 = zero-extend.
- MEM_TIMEOUT, 15, maximum cycles spent in MEM without mem_ack before abort; >= 1.
- INSTR_W, localparam = OPC_W + REG_W.

Ports:
- clk, in, 1, sole clock; all state updates on the rising edge.
- reset, in, 1, synchronous, active-low; block held in reset while reset == 0 at a rising edge.
- instr_valid, in, 1, instr holds a valid instruction.
- instr_ready, out, 1, block can accept an instruction this cycle.
- instr, in, INSTR_W, instruction word.
- opcode, out, OPC_W, latched opcode.
- register, out, REG_W, latched register field.
- imm, out, DATA_W, extended immediate; 0 for non-immediate ops.
- is_alu_op, out, 1, opcode MSB == 1.
- is_mem_op, out, 1, opcode is LD or ST.
- mem_rw, out, 1, opcode LSB (1 = write/ST); meaningful only when is_mem_op is 1.
- dec_valid, out, 1, one-cycle pulse: decode outputs are new.
- illegal, out, 1, one-cycle pulse alongside dec_valid for an undefined opcode.
- mem_req, out, 1, memory request, level-held until acknowledged.
- mem_ack, in, 1, memory acknowledge.
- increment_pc, out, 1, one-cycle PC-advance pulse.
- timeout_err, out, 1, one-cycle pulse on memory timeout.
- busy, out, 1, state != IDLE.

Behaviour:
- Reset (reset == 0 at an edge): state = IDLE, instruction register = 0, timeout counter = 0, and every output = 0, including instr_ready, mem_req and all pulses. Reset aborts any operation mid-flight, including MEM, with no increment_pc. First accept is possible at the first edge after reset returns to 1.
- Decode outputs (opcode, register, imm and class flags) are registered from the instruction register. They are stable from the DECODE cycle until the next accept.
- Legal opcodes: NOP 00000, LI 00001, LD 00010, ST 00011, SETACC 01010, and any opcode with MSB = 1 (ALU class, including INC 10001). All others are illegal.
- imm = extend(instr[REG_W-1:0]) for LI and INC only; otherwise 0.
- State machine:
  - IDLE: instr_ready = 1. On instr_valid & instr_ready, latch instr and go to DECODE.
  - DECODE (exactly one cycle): dec_valid = 1, instr_ready = 0.
    - Mem op: go to MEM with mem_req = 1 from the next cycle.
    - Otherwise: increment_pc = 1 this cycle and go to IDLE.
    - Illegal opcode: illegal = 1 and increment_pc = 1 (executes as a NOP), then IDLE.
  - MEM: mem_req = 1 and the counter increments each cycle.
    - On mem_ack: increment_pc = 1 in that cycle, mem_req = 0 from the next cycle, go to IDLE.
    - If the counter reaches MEM_TIMEOUT with no ack: timeout_err = 1, mem_req drops, no increment_pc, go to IDLE.
    - mem_ack on the timeout cycle counts as an ack: no error.
- mem_ack outside MEM is ignored.
- instr_valid while instr_ready == 0 is ignored; the source must hold it.
- Latency: accept at edge N gives dec_valid in cycle N+1. Non-mem throughput is one instruction per 2 cycles. A mem op takes 2 + ack-wait cycles.
- busy = 1 in DECODE and MEM.

Decomposition:
- Shared package decoder_pkg holds:
  - Opcode constants OP_NOP, OP_LI, OP_LD, OP_ST, OP_SETACC and OP_INC.
  - A state enum: IDLE, DECODE, MEM.
  - An is_legal function.
- No sub-module is needed; the immediate extension is one function in the package.

Test Plan:
- Reset held low for 3 cycles while instr_valid = 1 -> all outputs 0 and instr_ready = 0; one cycle after release, instr_ready = 1.
- instr = 8'b00001_101 (LI 5) with IMM_SIGNED = 0 -> next cycle dec_valid = 1, imm = 8'h05, register = 5, increment_pc = 1. With IMM_SIGNED = 1 -> imm = 8'hFD.
- ST, instr = 8'b00011_010, with mem_ack after 3 cycles of mem_req -> is_mem_op = 1, mem_rw = 1, mem_req high exactly 3 cycles, increment_pc pulses in the ack cycle, busy falls the next cycle.
- LD with mem_ack never asserted, MEM_TIMEOUT = 4 -> timeout_err pulses once, mem_req drops, no increment_pc, instr_ready = 1 afterwards.
- Opcode 00101 -> dec_valid = 1, illegal = 1, increment_pc = 1, is_alu_op = 0, is_mem_op = 0.
- Reset asserted in the second MEM cycle -> mem_req = 0 after that edge, no increment_pc, state IDLE.
